// File: rtl/csi2_rx_packet_parser.sv
// CSI-2 packet parser for 4-lane D-PHY byte stream: header/ECC decode, short events, long payload + CRC strip.
// Latency 1 cycle (all outputs registered); no backpressure, the PHY stream cannot be stalled.
module csi2_rx_packet_parser #(
    parameter int unsigned DROP_ECC_ERR = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      rx_data_i,
    input  logic [3:0]       rx_sync_i,
    input  logic             rx_valid_i,
    output logic             sp_valid_o,
    output logic [5:0]       sp_dt_o,
    output logic [1:0]       sp_vc_o,
    output logic [15:0]      sp_data_o,
    output logic             lp_start_o,
    output logic [5:0]       lp_dt_o,
    output logic [1:0]       lp_vc_o,
    output logic [15:0]      lp_wc_o,
    output logic             pl_valid_o,
    output logic [31:0]      pl_data_o,
    output logic [3:0]       pl_be_o,
    output logic             pl_last_o,
    output logic [15:0]      crc_o,
    output logic             crc_valid_o,
    output logic             ecc_err_o,
    output logic             trunc_err_o,
    output logic             lane_err_o,
    output logic [CNT_W-1:0] pkt_cnt_o
);

    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_TRAIL} state_t;

    state_t          r_state, w_state_nxt;
    logic [16:0]     r_rem, w_rem_nxt;
    logic [15:0]     r_crc, w_crc_nxt;

    logic            r_sp_vld, r_lp_start, r_pl_vld, r_pl_last, r_crc_vld;
    logic            r_ecc_err, r_trunc_err, r_lane_err;
    logic [5:0]      r_sp_dt, r_lp_dt;
    logic [1:0]      r_sp_vc, r_lp_vc;
    logic [15:0]     r_sp_data, r_lp_wc;
    logic [31:0]     r_pl_data;
    logic [3:0]      r_pl_be;
    logic [CNT_W-1:0] r_cnt;

    logic            w_sp_vld, w_lp_start, w_pl_vld, w_pl_last, w_crc_vld;
    logic            w_ecc_err, w_trunc_err, w_lane_err, w_cnt_inc;
    logic [3:0]      w_pl_be;

    logic [23:0]     w_d;
    logic [5:0]      w_ecc_calc;
    logic            w_ecc_bad, w_sync_full, w_sync_part;
    logic [16:0]     w_pl_left, w_take, w_rem_dec;
    logic [1:0]      w_lo_idx, w_hi_idx;

    assign w_d = rx_data_i[23:0];

    assign w_ecc_calc[0] = w_d[0]^w_d[1]^w_d[2]^w_d[4]^w_d[5]^w_d[7]^w_d[10]^w_d[11]^w_d[13]
                         ^ w_d[16]^w_d[20]^w_d[21]^w_d[22]^w_d[23];
    assign w_ecc_calc[1] = w_d[0]^w_d[1]^w_d[3]^w_d[4]^w_d[6]^w_d[8]^w_d[10]^w_d[12]^w_d[14]
                         ^ w_d[17]^w_d[20]^w_d[21]^w_d[22]^w_d[23];
    assign w_ecc_calc[2] = w_d[0]^w_d[2]^w_d[3]^w_d[5]^w_d[6]^w_d[9]^w_d[11]^w_d[12]^w_d[15]
                         ^ w_d[18]^w_d[20]^w_d[21]^w_d[22];
    assign w_ecc_calc[3] = w_d[1]^w_d[2]^w_d[3]^w_d[7]^w_d[8]^w_d[9]^w_d[13]^w_d[14]^w_d[15]
                         ^ w_d[19]^w_d[20]^w_d[21]^w_d[23];
    assign w_ecc_calc[4] = w_d[4]^w_d[5]^w_d[6]^w_d[7]^w_d[8]^w_d[9]^w_d[16]^w_d[17]^w_d[18]
                         ^ w_d[19]^w_d[20]^w_d[22]^w_d[23];
    assign w_ecc_calc[5] = w_d[10]^w_d[11]^w_d[12]^w_d[13]^w_d[14]^w_d[15]^w_d[16]^w_d[17]
                         ^ w_d[18]^w_d[19]^w_d[21]^w_d[22]^w_d[23];

    assign w_ecc_bad   = (w_ecc_calc != rx_data_i[29:24]);
    assign w_sync_full = (rx_sync_i == 4'hF);
    assign w_sync_part = (rx_sync_i != 4'h0) && !w_sync_full;

    // r_rem counts payload plus the two CRC bytes still to come.
    assign w_pl_left = (r_rem > 17'd2) ? (r_rem - 17'd2) : 17'd0;
    assign w_take    = (r_rem >= 17'd4) ? 17'd4 : r_rem;
    assign w_rem_dec = r_rem - w_take;
    assign w_lo_idx  = r_rem[1:0] - 2'd2;
    assign w_hi_idx  = r_rem[1:0] - 2'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_crc_nxt   = r_crc;
        w_sp_vld    = 1'b0;
        w_lp_start  = 1'b0;
        w_pl_vld    = 1'b0;
        w_pl_be     = 4'h0;
        w_pl_last   = 1'b0;
        w_crc_vld   = 1'b0;
        w_ecc_err   = 1'b0;
        w_trunc_err = 1'b0;
        w_lane_err  = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rx_valid_i && w_sync_full) begin
                    w_ecc_err = w_ecc_bad;
                    if (!(w_ecc_bad && (DROP_ECC_ERR != 0))) begin
                        w_cnt_inc = 1'b1;
                        if (rx_data_i[5:0] < 6'h10) begin
                            w_sp_vld = 1'b1;
                        end else begin
                            w_lp_start  = 1'b1;
                            w_rem_nxt   = {1'b0, rx_data_i[23:8]} + 17'd2;
                            w_state_nxt = S_PAYLOAD;
                        end
                    end
                end else if (w_sync_part) begin
                    w_lane_err = 1'b1;
                end
            end
            S_PAYLOAD: begin
                if (!rx_valid_i) begin
                    w_trunc_err = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_pl_be   = (w_pl_left >= 17'd4) ? 4'hF
                              : ((4'b0001 << w_pl_left[1:0]) - 4'd1);
                    w_pl_vld  = (w_pl_be != 4'h0);
                    w_pl_last = (w_pl_left != 17'd0) && (w_pl_left <= 17'd4);
                    if (r_rem <= 17'd5)
                        w_crc_nxt[7:0]  = rx_data_i[{w_lo_idx, 3'b000} +: 8];
                    if (r_rem <= 17'd4)
                        w_crc_nxt[15:8] = rx_data_i[{w_hi_idx, 3'b000} +: 8];
                    w_rem_nxt = w_rem_dec;
                    if (w_rem_dec == 17'd0) begin
                        w_crc_vld   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (w_rem_dec == 17'd1) begin
                        w_state_nxt = S_TRAIL;
                    end
                end
            end
            S_TRAIL: begin
                w_state_nxt = S_IDLE;
                if (!rx_valid_i) begin
                    w_trunc_err = 1'b1;
                end else begin
                    w_crc_nxt[15:8] = rx_data_i[7:0];
                    w_crc_vld       = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sp_vld    <= 1'b0;
            r_sp_dt     <= '0;
            r_sp_vc     <= '0;
            r_sp_data   <= '0;
            r_lp_start  <= 1'b0;
            r_lp_dt     <= '0;
            r_lp_vc     <= '0;
            r_lp_wc     <= '0;
            r_pl_vld    <= 1'b0;
            r_pl_data   <= '0;
            r_pl_be     <= '0;
            r_pl_last   <= 1'b0;
            r_crc       <= '0;
            r_crc_vld   <= 1'b0;
            r_ecc_err   <= 1'b0;
            r_trunc_err <= 1'b0;
            r_lane_err  <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_sp_vld    <= w_sp_vld;
            r_lp_start  <= w_lp_start;
            r_pl_vld    <= w_pl_vld;
            r_pl_data   <= w_pl_vld ? rx_data_i : 32'h0;
            r_pl_be     <= w_pl_be;
            r_pl_last   <= w_pl_last;
            r_crc       <= w_crc_nxt;
            r_crc_vld   <= w_crc_vld;
            r_ecc_err   <= w_ecc_err;
            r_trunc_err <= w_trunc_err;
            r_lane_err  <= w_lane_err;
            if (w_sp_vld) begin
                r_sp_dt   <= rx_data_i[5:0];
                r_sp_vc   <= rx_data_i[7:6];
                r_sp_data <= rx_data_i[23:8];
            end
            if (w_lp_start) begin
                r_lp_dt <= rx_data_i[5:0];
                r_lp_vc <= rx_data_i[7:6];
                r_lp_wc <= rx_data_i[23:8];
            end
            if (w_cnt_inc)
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign sp_valid_o  = r_sp_vld;
    assign sp_dt_o     = r_sp_dt;
    assign sp_vc_o     = r_sp_vc;
    assign sp_data_o   = r_sp_data;
    assign lp_start_o  = r_lp_start;
    assign lp_dt_o     = r_lp_dt;
    assign lp_vc_o     = r_lp_vc;
    assign lp_wc_o     = r_lp_wc;
    assign pl_valid_o  = r_pl_vld;
    assign pl_data_o   = r_pl_data;
    assign pl_be_o     = r_pl_be;
    assign pl_last_o   = r_pl_last;
    assign crc_o       = r_crc;
    assign crc_valid_o = r_crc_vld;
    assign ecc_err_o   = r_ecc_err;
    assign trunc_err_o = r_trunc_err;
    assign lane_err_o  = r_lane_err;
    assign pkt_cnt_o   = r_cnt;

endmodule

// File: tb/tb_csi2_rx_packet_parser.sv
// Directed bench for csi2_rx_packet_parser; a second instance runs with ECC errors kept and a 3-bit counter.
module tb_csi2_rx_packet_parser;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] rx_data_i = 32'h0;
    logic [3:0]  rx_sync_i = 4'h0;
    logic        rx_valid_i = 1'b0;

    logic        sp_valid_o, lp_start_o, pl_valid_o, pl_last_o, crc_valid_o;
    logic        ecc_err_o, trunc_err_o, lane_err_o;
    logic [5:0]  sp_dt_o, lp_dt_o;
    logic [1:0]  sp_vc_o, lp_vc_o;
    logic [15:0] sp_data_o, lp_wc_o, crc_o, pkt_cnt_o;
    logic [31:0] pl_data_o;
    logic [3:0]  pl_be_o;

    logic        nd_sp_valid, nd_lp_start, nd_pl_valid, nd_pl_last, nd_crc_valid;
    logic        nd_ecc_err, nd_trunc_err, nd_lane_err;
    logic [5:0]  nd_sp_dt, nd_lp_dt;
    logic [1:0]  nd_sp_vc, nd_lp_vc;
    logic [15:0] nd_sp_data, nd_lp_wc, nd_crc;
    logic [31:0] nd_pl_data;
    logic [3:0]  nd_pl_be;
    logic [2:0]  nd_pkt_cnt;

    int          chk = 0;
    int          pass = 0;
    logic [15:0] exp_cnt = 16'h0;
    logic [2:0]  exp_nd = 3'h0;

    always #5 clk_i = ~clk_i;

    csi2_rx_packet_parser dut (
        .clk_i(clk_i), .rst_i(rst_i), .rx_data_i(rx_data_i), .rx_sync_i(rx_sync_i),
        .rx_valid_i(rx_valid_i), .sp_valid_o(sp_valid_o), .sp_dt_o(sp_dt_o), .sp_vc_o(sp_vc_o),
        .sp_data_o(sp_data_o), .lp_start_o(lp_start_o), .lp_dt_o(lp_dt_o), .lp_vc_o(lp_vc_o),
        .lp_wc_o(lp_wc_o), .pl_valid_o(pl_valid_o), .pl_data_o(pl_data_o), .pl_be_o(pl_be_o),
        .pl_last_o(pl_last_o), .crc_o(crc_o), .crc_valid_o(crc_valid_o), .ecc_err_o(ecc_err_o),
        .trunc_err_o(trunc_err_o), .lane_err_o(lane_err_o), .pkt_cnt_o(pkt_cnt_o)
    );

    csi2_rx_packet_parser #(.DROP_ECC_ERR(0), .CNT_W(3)) dut_nd (
        .clk_i(clk_i), .rst_i(rst_i), .rx_data_i(rx_data_i), .rx_sync_i(rx_sync_i),
        .rx_valid_i(rx_valid_i), .sp_valid_o(nd_sp_valid), .sp_dt_o(nd_sp_dt), .sp_vc_o(nd_sp_vc),
        .sp_data_o(nd_sp_data), .lp_start_o(nd_lp_start), .lp_dt_o(nd_lp_dt), .lp_vc_o(nd_lp_vc),
        .lp_wc_o(nd_lp_wc), .pl_valid_o(nd_pl_valid), .pl_data_o(nd_pl_data), .pl_be_o(nd_pl_be),
        .pl_last_o(nd_pl_last), .crc_o(nd_crc), .crc_valid_o(nd_crc_valid), .ecc_err_o(nd_ecc_err),
        .trunc_err_o(nd_trunc_err), .lane_err_o(nd_lane_err), .pkt_cnt_o(nd_pkt_cnt)
    );

    // Parity masks: bit n set means D[n] participates in that parity bit.
    function automatic logic [5:0] ecc6(input logic [23:0] d);
        ecc6[0] = ^(d & 24'hF12CB7);
        ecc6[1] = ^(d & 24'hF2555B);
        ecc6[2] = ^(d & 24'h749A6D);
        ecc6[3] = ^(d & 24'hB8E38E);
        ecc6[4] = ^(d & 24'hDF03F0);
        ecc6[5] = ^(d & 24'hEFFC00);
    endfunction

    function automatic logic [31:0] hdr(input logic [7:0] di, input logic [15:0] wc);
        hdr = {2'b00, ecc6({wc, di}), wc, di};
    endfunction

    task automatic step(input logic [31:0] d, input logic [3:0] s, input logic v);
        rx_data_i = d; rx_sync_i = s; rx_valid_i = v;
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step(32'hFFFF_FFFF, 4'hF, 1'b1);
        step(32'h0, 4'h0, 1'b0);
        chk++; if ({sp_valid_o, lp_start_o, pl_valid_o, pl_last_o, crc_valid_o, ecc_err_o, trunc_err_o, lane_err_o} !== 8'h0)
            $display("FAIL reset_pulses got=%b exp=0", {sp_valid_o, lp_start_o, pl_valid_o, pl_last_o, crc_valid_o, ecc_err_o, trunc_err_o, lane_err_o}); else pass++;
        chk++; if ({pl_data_o, crc_o, pkt_cnt_o, sp_data_o, lp_wc_o} !== 96'h0)
            $display("FAIL reset_values data=%h crc=%h cnt=%h exp=0", pl_data_o, crc_o, pkt_cnt_o); else pass++;
        rst_i = 1'b0;
        exp_cnt = 16'h0; exp_nd = 3'h0;
    endtask

    task automatic test_short();
        step(32'h0700_0001, 4'hF, 1'b1);
        exp_cnt++; exp_nd++;
        chk++; if ({sp_valid_o, ecc_err_o, lp_start_o} !== 3'b100)
            $display("FAIL short_flags got=%b exp=100", {sp_valid_o, ecc_err_o, lp_start_o}); else pass++;
        chk++; if ({sp_vc_o, sp_dt_o, sp_data_o} !== {2'd0, 6'h01, 16'h0})
            $display("FAIL short_fields vc=%h dt=%h data=%h exp 0/01/0000", sp_vc_o, sp_dt_o, sp_data_o); else pass++;
        chk++; if (pkt_cnt_o !== 16'd1) $display("FAIL short_cnt got=%0d exp=1", pkt_cnt_o); else pass++;
        step(32'h0, 4'h0, 1'b0);
        chk++; if (sp_valid_o !== 1'b0) $display("FAIL short_pulse_width got=%b exp=0", sp_valid_o); else pass++;
    endtask

    task automatic test_ecc_err();
        step(32'h0600_0001, 4'hF, 1'b1);
        exp_nd++;
        chk++; if ({ecc_err_o, sp_valid_o} !== 2'b10)
            $display("FAIL ecc_drop_flags got=%b exp=10", {ecc_err_o, sp_valid_o}); else pass++;
        chk++; if (pkt_cnt_o !== exp_cnt) $display("FAIL ecc_drop_cnt got=%0d exp=%0d", pkt_cnt_o, exp_cnt); else pass++;
        chk++; if ({nd_ecc_err, nd_sp_valid, nd_sp_dt} !== {2'b11, 6'h01})
            $display("FAIL ecc_keep_flags got=%b/%b dt=%h exp=1/1 01", nd_ecc_err, nd_sp_valid, nd_sp_dt); else pass++;
        chk++; if (nd_pkt_cnt !== exp_nd) $display("FAIL ecc_keep_cnt got=%0d exp=%0d", nd_pkt_cnt, exp_nd); else pass++;
    endtask

    task automatic test_long_wc6();
        step(hdr(8'h2A, 16'd6), 4'hF, 1'b1);
        exp_cnt++; exp_nd++;
        chk++; if ({lp_start_o, ecc_err_o, lp_vc_o, lp_dt_o, lp_wc_o} !== {2'b10, 2'd0, 6'h2A, 16'd6})
            $display("FAIL wc6_hdr start=%b ecc=%b vc=%h dt=%h wc=%0d", lp_start_o, ecc_err_o, lp_vc_o, lp_dt_o, lp_wc_o); else pass++;
        chk++; if (pkt_cnt_o !== exp_cnt) $display("FAIL wc6_cnt got=%0d exp=%0d", pkt_cnt_o, exp_cnt); else pass++;
        step(32'h4433_2211, 4'h0, 1'b1);
        chk++; if ({pl_valid_o, pl_be_o, pl_last_o, pl_data_o, crc_valid_o} !== {1'b1, 4'hF, 1'b0, 32'h4433_2211, 1'b0})
            $display("FAIL wc6_w0 v=%b be=%h last=%b data=%h crcv=%b", pl_valid_o, pl_be_o, pl_last_o, pl_data_o, crc_valid_o); else pass++;
        step(32'hC1C0_6655, 4'h0, 1'b1);
        chk++; if ({pl_valid_o, pl_be_o, pl_last_o, pl_data_o[15:0]} !== {1'b1, 4'h3, 1'b1, 16'h6655})
            $display("FAIL wc6_w1 v=%b be=%h last=%b data=%h exp 1/3/1/6655", pl_valid_o, pl_be_o, pl_last_o, pl_data_o[15:0]); else pass++;
        chk++; if ({crc_valid_o, crc_o} !== {1'b1, 16'hC1C0})
            $display("FAIL wc6_crc v=%b crc=%h exp 1/C1C0", crc_valid_o, crc_o); else pass++;
        step(32'h0, 4'h0, 1'b0);
        chk++; if ({pl_valid_o, crc_valid_o, trunc_err_o} !== 3'b000)
            $display("FAIL wc6_idle got=%b exp=000", {pl_valid_o, crc_valid_o, trunc_err_o}); else pass++;
    endtask

    task automatic test_long_wc4();
        step(hdr(8'h2A, 16'd4), 4'hF, 1'b1);
        exp_cnt++; exp_nd++;
        step(32'hA4A3_A2A1, 4'h0, 1'b1);
        chk++; if ({pl_valid_o, pl_be_o, pl_last_o, crc_valid_o} !== {1'b1, 4'hF, 1'b1, 1'b0})
            $display("FAIL wc4_w0 v=%b be=%h last=%b crcv=%b", pl_valid_o, pl_be_o, pl_last_o, crc_valid_o); else pass++;
        step(32'h0000_B2B1, 4'h0, 1'b1);
        chk++; if ({pl_valid_o, pl_be_o, pl_last_o, crc_valid_o, crc_o} !== {1'b0, 4'h0, 1'b0, 1'b1, 16'hB2B1})
            $display("FAIL wc4_crc v=%b be=%h last=%b crcv=%b crc=%h exp crc B2B1", pl_valid_o, pl_be_o, pl_last_o, crc_valid_o, crc_o); else pass++;
    endtask

    task automatic test_long_wc5();
        step(hdr(8'h6B, 16'd5), 4'hF, 1'b1);
        exp_cnt++; exp_nd++;
        chk++; if ({lp_start_o, lp_vc_o, lp_dt_o, lp_wc_o} !== {1'b1, 2'd1, 6'h2B, 16'd5})
            $display("FAIL wc5_hdr start=%b vc=%h dt=%h wc=%0d", lp_start_o, lp_vc_o, lp_dt_o, lp_wc_o); else pass++;
        step(32'hA4A3_A2A1, 4'h0, 1'b1);
        chk++; if ({pl_be_o, pl_last_o} !== {4'hF, 1'b0}) $display("FAIL wc5_w0 be=%h last=%b exp F/0", pl_be_o, pl_last_o); else pass++;
        step(32'h00D2_D1A5, 4'h0, 1'b1);
        chk++; if ({pl_valid_o, pl_be_o, pl_last_o, pl_data_o[7:0], crc_valid_o, crc_o} !== {1'b1, 4'h1, 1'b1, 8'hA5, 1'b1, 16'hD2D1})
            $display("FAIL wc5_w1 v=%b be=%h last=%b d=%h crcv=%b crc=%h exp 1/1/1/A5/1/D2D1", pl_valid_o, pl_be_o, pl_last_o, pl_data_o[7:0], crc_valid_o, crc_o); else pass++;
    endtask

    task automatic test_long_wc7();
        step(hdr(8'h2A, 16'd7), 4'hF, 1'b1);
        exp_cnt++; exp_nd++;
        step(32'hA4A3_A2A1, 4'h0, 1'b1);
        step(32'hE1A7_A6A5, 4'h0, 1'b1);
        chk++; if ({pl_valid_o, pl_be_o, pl_last_o, crc_valid_o} !== {1'b1, 4'h7, 1'b1, 1'b0})
            $display("FAIL wc7_w1 v=%b be=%h last=%b crcv=%b exp 1/7/1/0", pl_valid_o, pl_be_o, pl_last_o, crc_valid_o); else pass++;
        step(32'h0000_00E2, 4'h0, 1'b1);
        chk++; if ({pl_valid_o, pl_last_o, crc_valid_o, crc_o} !== {1'b0, 1'b0, 1'b1, 16'hE2E1})
            $display("FAIL wc7_trail v=%b last=%b crcv=%b crc=%h exp 0/0/1/E2E1", pl_valid_o, pl_last_o, crc_valid_o, crc_o); else pass++;
    endtask

    task automatic test_wc0_back_to_back();
        step(hdr(8'h42, 16'hBEEF), 4'hF, 1'b1);
        exp_cnt++; exp_nd++;
        chk++; if ({sp_valid_o, sp_vc_o, sp_dt_o, sp_data_o} !== {1'b1, 2'd1, 6'h02, 16'hBEEF})
            $display("FAIL b2b_short v=%b vc=%h dt=%h data=%h", sp_valid_o, sp_vc_o, sp_dt_o, sp_data_o); else pass++;
        step(hdr(8'h2A, 16'd0), 4'hF, 1'b1);
        exp_cnt++; exp_nd++;
        chk++; if ({lp_start_o, lp_wc_o} !== {1'b1, 16'd0}) $display("FAIL wc0_hdr start=%b wc=%0d exp 1/0", lp_start_o, lp_wc_o); else pass++;
        step(32'h0000_F2F1, 4'h0, 1'b1);
        chk++; if ({pl_valid_o, pl_last_o, crc_valid_o, crc_o} !== {1'b0, 1'b0, 1'b1, 16'hF2F1})
            $display("FAIL wc0_crc v=%b last=%b crcv=%b crc=%h exp 0/0/1/F2F1", pl_valid_o, pl_last_o, crc_valid_o, crc_o); else pass++;
        step(hdr(8'h03, 16'h1234), 4'hF, 1'b1);
        exp_cnt++; exp_nd++;
        chk++; if ({sp_valid_o, sp_data_o} !== {1'b1, 16'h1234}) $display("FAIL b2b_after_long v=%b data=%h exp 1/1234", sp_valid_o, sp_data_o); else pass++;
        chk++; if (pkt_cnt_o !== exp_cnt) $display("FAIL b2b_cnt got=%0d exp=%0d", pkt_cnt_o, exp_cnt); else pass++;
        chk++; if (nd_pkt_cnt !== exp_nd) $display("FAIL b2b_nd_cnt got=%0d exp=%0d", nd_pkt_cnt, exp_nd); else pass++;
    endtask

    task automatic test_trunc();
        step(hdr(8'h2A, 16'd16), 4'hF, 1'b1);
        exp_cnt++; exp_nd++;
        step(32'h0403_0201, 4'h0, 1'b1);
        chk++; if ({pl_valid_o, pl_last_o} !== 2'b10) $display("FAIL trunc_w0 v=%b last=%b exp 1/0", pl_valid_o, pl_last_o); else pass++;
        step(32'h0807_0605, 4'h0, 1'b0);
        chk++; if ({trunc_err_o, pl_valid_o, pl_last_o, crc_valid_o} !== 4'b1000)
            $display("FAIL trunc_flags got=%b exp=1000", {trunc_err_o, pl_valid_o, pl_last_o, crc_valid_o}); else pass++;
        step(hdr(8'h2B, 16'd2), 4'hF, 1'b1);
        exp_cnt++; exp_nd++;
        chk++; if ({lp_start_o, trunc_err_o, lp_dt_o, lp_wc_o} !== {2'b10, 6'h2B, 16'd2})
            $display("FAIL trunc_recover start=%b trunc=%b dt=%h wc=%0d", lp_start_o, trunc_err_o, lp_dt_o, lp_wc_o); else pass++;
        step(32'hC2C1_2211, 4'h0, 1'b1);
        chk++; if ({pl_be_o, pl_last_o, crc_valid_o, crc_o} !== {4'h3, 1'b1, 1'b1, 16'hC2C1})
            $display("FAIL wc2_word be=%h last=%b crcv=%b crc=%h exp 3/1/1/C2C1", pl_be_o, pl_last_o, crc_valid_o, crc_o); else pass++;
    endtask

    task automatic test_lane_err();
        step(hdr(8'h01, 16'h0), 4'b0111, 1'b1);
        chk++; if ({lane_err_o, sp_valid_o, lp_start_o, ecc_err_o} !== 4'b1000)
            $display("FAIL lane_err_flags got=%b exp=1000", {lane_err_o, sp_valid_o, lp_start_o, ecc_err_o}); else pass++;
        chk++; if (pkt_cnt_o !== exp_cnt) $display("FAIL lane_err_cnt got=%0d exp=%0d", pkt_cnt_o, exp_cnt); else pass++;
        step(32'h0, 4'h0, 1'b1);
        chk++; if (lane_err_o !== 1'b0) $display("FAIL lane_err_clear got=%b exp=0", lane_err_o); else pass++;
    endtask

    task automatic test_reset_mid();
        step(hdr(8'h2A, 16'd16), 4'hF, 1'b1);
        step(32'h0403_0201, 4'h0, 1'b1);
        rst_i = 1'b1;
        step(32'h0807_0605, 4'h0, 1'b1);
        chk++; if ({pl_valid_o, pl_be_o, pl_data_o, trunc_err_o, crc_o, pkt_cnt_o} !== 70'h0)
            $display("FAIL rstmid_outputs v=%b be=%h data=%h trunc=%b crc=%h cnt=%0d exp all 0", pl_valid_o, pl_be_o, pl_data_o, trunc_err_o, crc_o, pkt_cnt_o); else pass++;
        rst_i = 1'b0;
        exp_cnt = 16'h0; exp_nd = 3'h0;
        step(32'h0C0B_0A09, 4'h0, 1'b1);
        chk++; if ({pl_valid_o, trunc_err_o} !== 2'b00) $display("FAIL rstmid_idle v=%b trunc=%b exp 0/0", pl_valid_o, trunc_err_o); else pass++;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 8; i++) begin
            step(32'h0700_0001, 4'hF, 1'b1);
            if (i == 6) begin
                chk++; if (nd_pkt_cnt !== 3'd7) $display("FAIL wrap_top got=%0d exp=7", nd_pkt_cnt); else pass++;
            end
        end
        chk++; if (nd_pkt_cnt !== 3'd0) $display("FAIL wrap_zero got=%0d exp=0", nd_pkt_cnt); else pass++;
        chk++; if (pkt_cnt_o !== 16'd8) $display("FAIL wrap_wide got=%0d exp=8", pkt_cnt_o); else pass++;
    endtask

    initial begin
        test_reset();
        test_short();
        test_ecc_err();
        test_long_wc6();
        test_long_wc4();
        test_long_wc5();
        test_long_wc7();
        test_wc0_back_to_back();
        test_trunc();
        test_lane_err();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
